// File: rtl/canvas_pkg.sv
// Shared canvas definitions used by the port arbiter, the mouse writer and the recognizer.
package canvas_pkg;
  localparam int CANVAS_AW    = 10;
  localparam int CANVAS_DEPTH = 1024;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } canvas_arb_state_t;
endpackage

// File: rtl/canvas_port_arbiter_clear_sweeper.sv
// Full-canvas clear sweep: walks sweep_addr 0..DEPTH-1 once per start, then pulses done.
module clear_sweeper
  import canvas_pkg::*;
#(
  parameter int DEPTH = CANVAS_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic [CANVAS_AW-1:0] sweep_addr,
  output logic                 busy,
  output logic                 done
);
  localparam logic [CANVAS_AW-1:0] LAST = CANVAS_AW'(DEPTH - 1);

  // A start while busy is ignored so the sweep cannot be restarted or extended.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      sweep_addr <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        if (sweep_addr == LAST) begin
          busy       <= 1'b0;
          done       <= 1'b1;
          sweep_addr <= '0;
        end else begin
          sweep_addr <= sweep_addr + 1'b1;
        end
      end else if (start) begin
        busy       <= 1'b1;
        sweep_addr <= '0;
      end
    end
  end
endmodule

// File: rtl/canvas_port_arbiter.sv
// Owner of the canvas RAM read/write port: read > draw priority with a draw starvation
// guard, plus a hardware clear sweep that locks out both requesters while it runs.
module canvas_port_arbiter
  import canvas_pkg::*;
#(
  parameter int STARVE_LIMIT = 15,
  parameter int DEPTH        = CANVAS_DEPTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 draw_req,
  input  logic [CANVAS_AW-1:0] draw_addr,
  input  logic                 draw_data,
  output logic                 draw_gnt,
  input  logic                 rd_req,
  input  logic [CANVAS_AW-1:0] rd_addr,
  output logic                 rd_gnt,
  output logic                 rd_valid,
  output logic                 rd_data,
  input  logic                 clear_start,
  output logic                 clear_busy,
  output logic                 clear_done,
  output logic [CANVAS_AW-1:0] mem_addr,
  output logic                 mem_wdata,
  output logic                 mem_we,
  input  logic                 mem_rdata
);
  // Handshake: a requester holds req and its address/data until its gnt is seen high;
  // gnt is combinational and means the access happens at the edge ending this cycle.
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  canvas_arb_state_t    state;
  logic                 sweep_busy;
  logic                 sweep_done;
  logic [CANVAS_AW-1:0] sweep_addr;
  logic [SW-1:0]        starve_cnt;
  logic                 arb_en;
  logic                 starved;

  clear_sweeper #(.DEPTH(DEPTH)) u_sweeper (
    .clk        (clk),
    .rst        (rst),
    .start      (clear_start),
    .sweep_addr (sweep_addr),
    .busy       (sweep_busy),
    .done       (sweep_done)
  );

  assign state      = sweep_busy ? CLEAR : IDLE;
  assign clear_busy = sweep_busy;
  assign clear_done = sweep_done;

  // Gating with rst keeps the port quiet during reset, so an aborted sweep writes nothing more.
  assign arb_en   = (state == IDLE) && !rst;
  assign starved  = (starve_cnt == STARVE_MAX);
  assign draw_gnt = arb_en && draw_req && (!rd_req || starved);
  assign rd_gnt   = arb_en && rd_req && !(draw_req && starved);

  always_comb begin
    mem_addr  = '0;
    mem_wdata = 1'b0;
    mem_we    = 1'b0;
    if ((state == CLEAR) && !rst) begin
      mem_addr = sweep_addr;
      mem_we   = 1'b1;
    end else if (draw_gnt) begin
      mem_addr  = draw_addr;
      mem_wdata = draw_data;
      mem_we    = 1'b1;
    end else if (rd_gnt) begin
      mem_addr = rd_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (state == IDLE) begin
      if (draw_req && !draw_gnt) begin
        if (!starved) starve_cnt <= starve_cnt + 1'b1;
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= 1'b0;
    end else begin
      rd_valid <= rd_gnt;
      if (rd_gnt) rd_data <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_canvas_port_arbiter.sv
// Bench for canvas_port_arbiter: a vector table for single-cycle arbitration plus
// hand-written sequences for starvation, clear sweep, reset abort and start/read overlap.
module tb_canvas_port_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       draw_req, draw_data, rd_req, clear_start;
  logic [9:0] draw_addr, rd_addr;
  logic       draw_gnt, rd_gnt, rd_valid, rd_data, clear_busy, clear_done;
  logic [9:0] mem_addr;
  logic       mem_wdata, mem_we, mem_rdata;
  logic       mem [1024];

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  canvas_port_arbiter dut (
    .clk(clk), .rst(rst),
    .draw_req(draw_req), .draw_addr(draw_addr), .draw_data(draw_data), .draw_gnt(draw_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .clear_start(clear_start), .clear_busy(clear_busy), .clear_done(clear_done),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  // Canvas RAM model: synchronous write, asynchronous read.
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic       draw_req;
    logic [9:0] draw_addr;
    logic       draw_data;
    logic       rd_req;
    logic [9:0] rd_addr;
    logic       e_draw_gnt;
    logic       e_rd_gnt;
    logic       e_mem_we;
    logic [9:0] e_mem_addr;
    logic       e_mem_wdata;
    logic       e_rd_valid;
    logic       e_rd_data;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [9:0] a, input logic d);
    draw_req = 1'b1; draw_addr = a; draw_data = d;
    #1;
    chk("write_gnt", draw_gnt, 1);
    tick();
    draw_req = 1'b0;
  endtask

  task automatic do_read(input logic [9:0] a, output logic v);
    rd_req = 1'b1; rd_addr = a;
    #1;
    chk("read_gnt", rd_gnt, 1);
    tick();
    rd_req = 1'b0;
    #1;
    chk("read_valid", rd_valid, 1);
    v = rd_data;
  endtask

  initial begin
    int errs;
    int gerrs;
    int dones;
    int n;
    logic v;

    for (int k = 0; k < 1024; k++) mem[k] = 1'b0;
    rst = 1'b1; draw_req = 0; draw_addr = 0; draw_data = 0;
    rd_req = 0; rd_addr = 0; clear_start = 0;
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("rst_draw_gnt", draw_gnt, 0);
    chk("rst_rd_gnt", rd_gnt, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_clear_busy", clear_busy, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);

    vecs[0] = '{1, 10'd3, 1, 0, 10'd0, 1, 0, 1, 10'd3, 1, 0, 0};
    vecs[1] = '{0, 10'd0, 0, 1, 10'd3, 0, 1, 0, 10'd3, 0, 0, 0};
    vecs[2] = '{0, 10'd0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0, 1, 1};
    vecs[3] = '{1, 10'd4, 1, 1, 10'd9, 0, 1, 0, 10'd9, 0, 0, 0};
    vecs[4] = '{1, 10'd4, 0, 0, 10'd0, 1, 0, 1, 10'd4, 0, 1, 0};
    vecs[5] = '{0, 10'd0, 0, 0, 10'd0, 0, 0, 0, 10'd0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      draw_req = vecs[i].draw_req; draw_addr = vecs[i].draw_addr; draw_data = vecs[i].draw_data;
      rd_req = vecs[i].rd_req; rd_addr = vecs[i].rd_addr;
      #1;
      chk($sformatf("vec%0d_draw_gnt", i), draw_gnt, vecs[i].e_draw_gnt);
      chk($sformatf("vec%0d_rd_gnt", i), rd_gnt, vecs[i].e_rd_gnt);
      chk($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_mem_we);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_mem_addr);
      chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_mem_wdata);
      chk($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].e_rd_valid);
      if (vecs[i].e_rd_valid) chk($sformatf("vec%0d_rd_data", i), rd_data, vecs[i].e_rd_data);
      tick();
    end
    draw_req = 0; rd_req = 0;

    // Read/draw contention: read wins 15 cycles, draw forced through on the 16th.
    do_write(10'd5, 1'b1);
    rd_req = 1; rd_addr = 10'd5; draw_req = 1; draw_addr = 10'd7; draw_data = 1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (c < 15) begin
        chk($sformatf("cont%0d_rd_gnt", c), rd_gnt, 1);
        chk($sformatf("cont%0d_draw_gnt", c), draw_gnt, 0);
      end else begin
        chk("cont15_draw_gnt", draw_gnt, 1);
        chk("cont15_rd_gnt", rd_gnt, 0);
        chk("cont15_mem_we", mem_we, 1);
        chk("cont15_mem_addr", mem_addr, 7);
      end
      if (c >= 1) begin
        chk($sformatf("cont%0d_rd_valid", c), rd_valid, 1);
        chk($sformatf("cont%0d_rd_data", c), rd_data, 1);
      end
      tick();
    end
    rd_req = 0; draw_req = 0;
    #1;
    chk("cont_after_rd_valid", rd_valid, 0);

    // Draw alone at the top address, then read it back.
    do_write(10'd1023, 1'b1);
    do_read(10'd1023, v);
    chk("draw1023_readback", v, 1);

    // Full clear with requests and a second start arriving mid-sweep.
    for (int k = 0; k < 1024; k++) do_write(k[9:0], 1'b1);
    clear_start = 1;
    #1;
    chk("clr_start_busy", clear_busy, 0);
    tick();
    clear_start = 0;
    errs = 0; gerrs = 0; dones = 0; n = 0;
    while (clear_busy === 1'b1 && n < 1100) begin
      if (n == 200) begin
        draw_req = 1; draw_addr = 10'd9; draw_data = 1; rd_req = 1; rd_addr = 10'd5;
      end
      if (n == 500) clear_start = 1;
      if (n == 501) clear_start = 0;
      #1;
      if (mem_addr !== n[9:0] || mem_we !== 1'b1 || mem_wdata !== 1'b0) errs++;
      if (draw_gnt || rd_gnt) gerrs++;
      if (clear_done) dones++;
      tick();
      n++;
    end
    chk("sweep_cycles", n, 1024);
    chk("sweep_port_errs", errs, 0);
    chk("sweep_grant_errs", gerrs, 0);
    chk("sweep_early_done", dones, 0);
    #1;
    chk("sweep_done_pulse", clear_done, 1);
    chk("sweep_done_busy", clear_busy, 0);
    chk("sweep_resume_rd_gnt", rd_gnt, 1);
    chk("sweep_resume_draw_gnt", draw_gnt, 0);
    tick();
    draw_req = 0; rd_req = 0;
    #1;
    chk("sweep_done_single", clear_done, 0);
    errs = 0;
    rd_req = 1;
    for (int k = 0; k < 1024; k++) begin
      rd_addr = k[9:0];
      tick();
      if (rd_valid !== 1'b1 || rd_data !== 1'b0) errs++;
    end
    rd_req = 0;
    chk("clear_readback_errs", errs, 0);

    // Reset mid-sweep at address 300.
    tick();
    do_write(10'd299, 1); do_write(10'd300, 1); do_write(10'd301, 1);
    do_write(10'd700, 1); do_write(10'd1023, 1);
    clear_start = 1;
    tick();
    clear_start = 0;
    n = 0;
    while (mem_addr !== 10'd300 && n < 2000) begin
      tick();
      n++;
    end
    chk("abort_reach_300", mem_addr, 300);
    rst = 1;
    tick();
    rst = 0;
    #1;
    chk("abort_busy", clear_busy, 0);
    chk("abort_done", clear_done, 0);
    chk("abort_mem_we", mem_we, 0);
    chk("abort_mem_addr", mem_addr, 0);
    chk("abort_rd_valid", rd_valid, 0);
    dones = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (clear_done || clear_busy) dones++;
    end
    chk("abort_no_done", dones, 0);
    do_read(10'd299, v); chk("abort_cell299", v, 0);
    do_read(10'd300, v); chk("abort_cell300", v, 1);
    do_read(10'd301, v); chk("abort_cell301", v, 1);
    do_read(10'd700, v); chk("abort_cell700", v, 1);
    do_read(10'd1023, v); chk("abort_cell1023", v, 1);

    // Simultaneous clear_start and read in IDLE.
    tick();
    clear_start = 1; rd_req = 1; rd_addr = 10'd300;
    #1;
    chk("simul_rd_gnt", rd_gnt, 1);
    chk("simul_busy_before", clear_busy, 0);
    tick();
    clear_start = 0; rd_req = 0;
    #1;
    chk("simul_busy_after", clear_busy, 1);
    chk("simul_rd_valid", rd_valid, 1);
    chk("simul_rd_data", rd_data, 1);
    n = 0;
    while (clear_busy === 1'b1 && n < 1100) begin
      tick();
      n++;
    end
    chk("simul_sweep_cycles", n, 1024);
    chk("simul_done", clear_done, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
